// File: rtl/sram_march_ctrl_pkg.sv
// Shared constants and FSM encoding for the SRAM march-test controller.
package sram_march_ctrl_pkg;
    localparam int unsigned SMC_DW     = 64;
    localparam int unsigned SMC_AW     = 6;
    localparam int unsigned SMC_RD_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        DRAIN,
        DONE
    } march_state_e;
endpackage

// File: rtl/sram_rd_pipe.sv
// Delays the expected read data, its address and a valid flag by RD_LAT cycles
// so they line up with the SRAM read data.
module sram_rd_pipe
    import sram_march_ctrl_pkg::*;
#(
    parameter int unsigned DW     = SMC_DW,
    parameter int unsigned AW     = SMC_AW,
    parameter int unsigned RD_LAT = SMC_RD_LAT
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_vld,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_exp,
    output logic          o_vld,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_exp
);
    logic [RD_LAT:1]         vld_pipe;
    logic [RD_LAT:1][AW-1:0] addr_pipe;
    logic [RD_LAT:1][DW-1:0] exp_pipe;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            exp_pipe  <= '0;
        end else begin
            vld_pipe[1]  <= i_vld;
            addr_pipe[1] <= i_addr;
            exp_pipe[1]  <= i_exp;
            for (int i = 2; i <= int'(RD_LAT); i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                exp_pipe[i]  <= exp_pipe[i-1];
            end
        end
    end

    assign o_vld  = vld_pipe[RD_LAT];
    assign o_addr = addr_pipe[RD_LAT];
    assign o_exp  = exp_pipe[RD_LAT];
endmodule

// File: rtl/sram_march_ctrl.sv
// Two-pass walking-one / walking-zero SRAM test: write all, read-compare all,
// then repeat with inverted patterns. Reports error count and first failing address.
module sram_march_ctrl
    import sram_march_ctrl_pkg::*;
#(
    parameter int unsigned DW     = SMC_DW,
    parameter int unsigned AW     = SMC_AW,
    parameter int unsigned RD_LAT = SMC_RD_LAT
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_pass,
    output logic [AW+1:0] o_err_cnt,
    output logic [AW-1:0] o_fail_addr,
    output logic          o_fail_valid,
    output logic [DW-1:0] o_mem_data,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_wen,
    output logic          o_mem_cen,
    output logic          o_mem_oen,
    input  logic [DW-1:0] i_mem_data
);
    localparam int unsigned   DCW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [AW-1:0] LAST = '1;

    march_state_e   state, state_d;
    logic           ph, ph_d;
    logic [DCW-1:0] drn_cnt, drn_cnt_d;

    logic [AW-1:0]  addr_d, addr_inc, fail_addr_d;
    logic [DW-1:0]  data_d, rd_exp;
    logic           cen_d, wen_d, oen_d, busy_d, done_d, pass_d, fail_valid_d;
    logic [AW+1:0]  err_d;

    logic           pipe_vld, mism;
    logic [AW-1:0]  pipe_addr;
    logic [DW-1:0]  pipe_exp;

    function automatic logic [DW-1:0] pattern(input logic p, input logic [AW-1:0] a);
        pattern = p ? ~(ONE << a) : (ONE << a);
    endfunction

    assign addr_inc = o_mem_addr + 1'b1;
    assign rd_exp   = pattern(ph, o_mem_addr);
    assign mism     = pipe_vld && (i_mem_data != pipe_exp);

    sram_rd_pipe #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) u_rd_pipe (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_vld  (o_mem_cen & o_mem_oen),
        .i_addr (o_mem_addr),
        .i_exp  (rd_exp),
        .o_vld  (pipe_vld),
        .o_addr (pipe_addr),
        .o_exp  (pipe_exp)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= IDLE;
            ph      <= 1'b0;
            drn_cnt <= '0;
        end else begin
            state   <= state_d;
            ph      <= ph_d;
            drn_cnt <= drn_cnt_d;
        end
    end

    always_comb begin
        state_d      = state;
        ph_d         = ph;
        drn_cnt_d    = drn_cnt;
        addr_d       = o_mem_addr;
        data_d       = o_mem_data;
        cen_d        = 1'b0;
        wen_d        = 1'b0;
        oen_d        = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pass_d       = o_pass;
        err_d        = o_err_cnt;
        fail_addr_d  = o_fail_addr;
        fail_valid_d = o_fail_valid;

        if (mism) begin
            if (o_err_cnt != '1) err_d = o_err_cnt + 1'b1;
            if (!o_fail_valid) begin
                fail_addr_d  = pipe_addr;
                fail_valid_d = 1'b1;
            end
        end

        unique case (state)
            IDLE: if (i_start) begin
                state_d      = WR;
                ph_d         = 1'b0;
                err_d        = '0;
                fail_valid_d = 1'b0;
                addr_d       = '0;
                data_d       = pattern(1'b0, '0);
                cen_d        = 1'b1;
                wen_d        = 1'b1;
                busy_d       = 1'b1;
            end
            WR: begin
                busy_d = 1'b1;
                cen_d  = 1'b1;
                if (o_mem_addr == LAST) begin
                    state_d = RD;
                    addr_d  = '0;
                    oen_d   = 1'b1;
                end else begin
                    wen_d  = 1'b1;
                    addr_d = addr_inc;
                    data_d = pattern(ph, addr_inc);
                end
            end
            RD: begin
                busy_d = 1'b1;
                if (o_mem_addr == LAST) begin
                    state_d   = DRAIN;
                    drn_cnt_d = '0;
                end else begin
                    cen_d  = 1'b1;
                    oen_d  = 1'b1;
                    addr_d = addr_inc;
                end
            end
            DRAIN: begin
                // Final compare lands on the last drain cycle; pass uses the updated count.
                if (drn_cnt == DCW'(RD_LAT - 1)) begin
                    if (!ph) begin
                        state_d = WR;
                        ph_d    = 1'b1;
                        addr_d  = '0;
                        data_d  = pattern(1'b1, '0);
                        cen_d   = 1'b1;
                        wen_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    drn_cnt_d = drn_cnt + 1'b1;
                    busy_d    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            o_mem_cen    <= 1'b0;
            o_mem_wen    <= 1'b0;
            o_mem_oen    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_err_cnt    <= '0;
            o_fail_addr  <= '0;
            o_fail_valid <= 1'b0;
        end else begin
            o_mem_addr   <= addr_d;
            o_mem_data   <= data_d;
            o_mem_cen    <= cen_d;
            o_mem_wen    <= wen_d;
            o_mem_oen    <= oen_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
            o_pass       <= pass_d;
            o_err_cnt    <= err_d;
            o_fail_addr  <= fail_addr_d;
            o_fail_valid <= fail_valid_d;
        end
    end
endmodule

// File: doc/sram_march_ctrl.md
SRAM_MARCH_CTRL -- requirements
Module: sram_march_ctrl

Interface
REQ-001 SHALL have parameter DW, default 64, SRAM data width.
REQ-002 SHALL have parameter AW, default 6, SRAM address width; depth = 2**AW.
REQ-003 SHALL have parameter RD_LAT, default 1, cycles from a read strobe to valid SRAM read data.
REQ-004 i_clk  input  1  single clock; all logic on posedge.
REQ-005 i_rstn  input  1  reset; asynchronous, active-low.
REQ-006 i_start  input  1  one-cycle start request.
REQ-007 o_busy  output  1  high while a test is running.
REQ-008 o_done  output  1  one-cycle pulse when a test ends.
REQ-009 o_pass  output  1  result of the last completed test; 1 means no mismatches.
REQ-010 o_err_cnt  output  AW+2  mismatch count of the last or current test.
REQ-011 o_fail_addr  output  AW  address of the first mismatch.
REQ-012 o_fail_valid  output  1  o_fail_addr holds a captured address.
REQ-013 o_mem_data  output  DW  SRAM write data.
REQ-014 o_mem_addr  output  AW  SRAM address.
REQ-015 o_mem_wen, o_mem_cen, o_mem_oen  output  1 each  SRAM write, chip and output enables; active-high.
REQ-016 i_mem_data  input  DW  SRAM read data.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, WR, RD, DRAIN and DONE. A phase bit PH selects one of two passes.
REQ-019 IDLE:
- i_start=1 SHALL set PH=0, clear o_err_cnt and o_fail_valid, and enter WR with address 0.
- o_pass and o_fail_addr SHALL be held until then.
REQ-020 WR: one write per cycle, addresses 0..2**AW-1 ascending, with cen=1, wen=1, oen=0.
- Data = 1<<addr when PH=0.
- Data = ~(1<<addr) when PH=1.
- After the last address, go to RD with address 0.
REQ-021 RD: one read per cycle, same address order, with cen=1, wen=0, oen=1. After the last address, go to DRAIN.
REQ-022 The expected data and address SHALL be delayed RD_LAT cycles and compared with i_mem_data.
- Each mismatch increments o_err_cnt; the counter does not wrap, since the maximum count is 2**(AW+1).
- The first mismatch latches o_fail_addr and sets o_fail_valid.
REQ-023 DRAIN: strobes low for RD_LAT cycles so the final compares complete.
- Then, if PH=0: PH=1, back to WR at address 0.
- Else: go to DONE.
REQ-024 DONE: o_done=1 and o_pass=(o_err_cnt==0) for one cycle, then IDLE.
REQ-025 o_busy SHALL be 1 in WR, RD and DRAIN. For defaults this is exactly 2*(64+64+1)=258 cycles, followed by o_done in the next cycle.
REQ-026 i_start SHALL be ignored in every state except IDLE.
REQ-027 Outside WR and RD, o_mem_cen, o_mem_wen and o_mem_oen SHALL be 0, and o_mem_addr and o_mem_data SHALL hold their last values.

Reset
REQ-028 With i_rstn=0, the following SHALL be forced asynchronously:
- state=IDLE, PH=0;
- all SRAM strobes, o_mem_addr and o_mem_data = 0;
- o_busy, o_done, o_pass, o_fail_valid = 0;
- o_err_cnt, o_fail_addr = 0;
- delay pipeline cleared.
REQ-029 Reset mid-test SHALL abort the test with no o_done pulse. The strobes SHALL drop in the same cycle as reset assertion.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the default DW, AW and RD_LAT constants.
REQ-031 The RD_LAT-deep expected-data/address/valid delay line SHALL be one sub-module, sram_rd_pipe. The top SHALL instantiate spsram_extension only in the bench, never inside this block.

Verification
REQ-032 Fault-free SRAM model, start pulse → o_busy high 258 cycles, o_done pulse, o_pass=1, o_err_cnt=0, o_fail_valid=0.
REQ-033 Model with bit 5 of address 5 stuck-0 → o_pass=0, o_err_cnt=1, o_fail_addr=5.
REQ-034 Model with bit 0 stuck-1 at all addresses → o_err_cnt=64, o_fail_addr=1, o_pass=0.
REQ-035 Extra i_start pulses at cycles 10 and 200 of a run → no restart; o_done still occurs once at cycle 259.
REQ-036 i_rstn low at cycle 100 of a run → strobes 0 immediately, no o_done; a new start then gives a clean 258-cycle pass.
REQ-037 Two back-to-back tests, faulty model then fault-free model → the second test reports o_err_cnt=0, o_fail_valid=0, o_pass=1.
